dbg_entry_ctrl: RTL and testbench

Debug-mode entry/exit controller that consumes the halt sources of the core (`breakpoint` from the hardware triggers, ebreak, debug-module haltreq, single-step), drains the pipeline and holds the core halted. On resumereq it redirects fetch back to `dpc`. It sits between the trigger logic, the pipeline control and the debug-module halt/resume interface, and owns `dpc` and `dcsr.cause`.

---
 rtl/dbg_entry_ctrl_pkg.sv | 22 ++
 rtl/dbg_cause_enc.sv | 33 +++
 rtl/dbg_entry_ctrl.sv | 109 ++++++++++
 tb/tb_dbg_entry_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dbg_entry_ctrl_pkg.sv
// Shared encodings for the debug entry controller: halt causes, FSM states, capture-PC select.
package dbg_entry_ctrl_pkg;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_STEP   = 3'd1;
    localparam logic [2:0] ST_FLUSH  = 3'd2;
    localparam logic [2:0] ST_HALTED = 3'd3;
    localparam logic [2:0] ST_RESUME = 3'd4;

    typedef enum logic [1:0] {
        PC_SEL_MEM = 2'd0,
        PC_SEL_EX  = 2'd1,
        PC_SEL_RET = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/dbg_cause_enc.sv
// Priority encoder over the halt sources: trigger > ebreak > haltreq > step.
module dbg_cause_enc
    import dbg_entry_ctrl_pkg::*;
(
    input  logic       i_breakpoint,
    input  logic       i_ebreak,
    input  logic       i_haltreq,
    input  logic       i_step_retire,
    output logic       o_entry,
    output logic [2:0] o_cause,
    output pc_sel_e    o_pc_sel
);

    always_comb begin
        o_entry  = 1'b1;
        o_cause  = CAUSE_NONE;
        o_pc_sel = PC_SEL_EX;
        if (i_breakpoint) begin
            o_cause  = CAUSE_TRIGGER;
            o_pc_sel = PC_SEL_MEM;
        end else if (i_ebreak) begin
            o_cause  = CAUSE_EBREAK;
        end else if (i_haltreq) begin
            o_cause  = CAUSE_HALTREQ;
        end else if (i_step_retire) begin
            o_cause  = CAUSE_STEP;
            o_pc_sel = PC_SEL_RET;
        end else begin
            o_entry  = 1'b0;
        end
    end

endmodule

// File: rtl/dbg_entry_ctrl.sv
// Debug-mode entry/exit FSM; owns dpc and dcsr.cause.
//   RUN    | normal execution, halt sources armed
//   STEP   | single instruction running, next retire re-halts
//   FLUSH  | entry taken, draining pipeline
//   HALTED | core halted, debugger may write dpc
//   RESUME | one-cycle redirect to dpc with resumeack
module dbg_entry_ctrl
    import dbg_entry_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  breakpoint,
    input  logic [ADDR_WIDTH-1:0] pc_mem,
    input  logic                  ebreak_ex,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic                  haltreq,
    input  logic                  resumereq,
    input  logic                  dcsr_step,
    input  logic                  retire_valid,
    input  logic [ADDR_WIDTH-1:0] retire_next_pc,
    input  logic                  pipe_empty,
    input  logic                  dpc_wr_en,
    input  logic [ADDR_WIDTH-1:0] dpc_wr_data,
    output logic                  dbg_mode,
    output logic                  pipe_flush,
    output logic                  halted,
    output logic                  resumeack,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] dpc,
    output logic [2:0]            dcsr_cause
);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_dpc;
    logic [2:0]            r_cause;

    logic                  w_armed;
    logic                  w_step_retire;
    logic                  w_enc_entry;
    logic [2:0]            w_enc_cause;
    pc_sel_e               w_pc_sel;
    logic [ADDR_WIDTH-1:0] w_capture_pc;

    assign w_armed       = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_step_retire = (r_state == ST_STEP) && retire_valid;

    dbg_cause_enc u_cause_enc (
        .i_breakpoint  (breakpoint),
        .i_ebreak      (ebreak_ex),
        .i_haltreq     (haltreq),
        .i_step_retire (w_step_retire),
        .o_entry       (w_enc_entry),
        .o_cause       (w_enc_cause),
        .o_pc_sel      (w_pc_sel)
    );

    always_comb begin
        w_capture_pc = pc_ex;
        case (w_pc_sel)
            PC_SEL_MEM: w_capture_pc = pc_mem;
            PC_SEL_RET: w_capture_pc = retire_next_pc;
            default:    w_capture_pc = pc_ex;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= ST_RUN;
            r_dpc   <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_RUN, ST_STEP: begin
                    if (w_armed && w_enc_entry) begin
                        r_dpc   <= w_capture_pc;
                        r_cause <= w_enc_cause;
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (pipe_empty) r_state <= ST_HALTED;
                end
                ST_HALTED: begin
                    // dpc is only debugger-writable while halted
                    if (dpc_wr_en) r_dpc <= dpc_wr_data;
                    if (resumereq) r_state <= ST_RESUME;
                end
                ST_RESUME: begin
                    r_state <= dcsr_step ? ST_STEP : ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign dbg_mode       = (r_state == ST_FLUSH) || (r_state == ST_HALTED) ||
                            (r_state == ST_RESUME);
    assign pipe_flush     = (r_state == ST_FLUSH);
    assign halted         = (r_state == ST_HALTED);
    assign resumeack      = (r_state == ST_RESUME);
    assign redirect_valid = (r_state == ST_RESUME);
    assign redirect_pc    = r_dpc;
    assign dpc            = r_dpc;
    assign dcsr_cause     = r_cause;

endmodule

// File: tb/tb_dbg_entry_ctrl.sv
// Table-driven directed bench for dbg_entry_ctrl; each row is one cycle of inputs and the outputs expected after that edge.
module tb_dbg_entry_ctrl;

    typedef struct {
        bit        rst;
        bit        bp;
        bit [31:0] pcm;
        bit        eb;
        bit [31:0] pce;
        bit        hr;
        bit        rr;
        bit        st;
        bit        rv;
        bit [31:0] rnpc;
        bit        pe;
        bit        we;
        bit [31:0] wd;
        bit        e_dbg;
        bit        e_flush;
        bit        e_halt;
        bit        e_ack;
        bit [31:0] e_dpc;
        bit [2:0]  e_cause;
    } vec_t;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        breakpoint = 1'b0;
    logic [31:0] pc_mem = '0;
    logic        ebreak_ex = 1'b0;
    logic [31:0] pc_ex = '0;
    logic        haltreq = 1'b0;
    logic        resumereq = 1'b0;
    logic        dcsr_step = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_next_pc = '0;
    logic        pipe_empty = 1'b0;
    logic        dpc_wr_en = 1'b0;
    logic [31:0] dpc_wr_data = '0;
    logic        dbg_mode;
    logic        pipe_flush;
    logic        halted;
    logic        resumeack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] dpc;
    logic [2:0]  dcsr_cause;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    dbg_entry_ctrl #(.ADDR_WIDTH(32)) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .breakpoint     (breakpoint),
        .pc_mem         (pc_mem),
        .ebreak_ex      (ebreak_ex),
        .pc_ex          (pc_ex),
        .haltreq        (haltreq),
        .resumereq      (resumereq),
        .dcsr_step      (dcsr_step),
        .retire_valid   (retire_valid),
        .retire_next_pc (retire_next_pc),
        .pipe_empty     (pipe_empty),
        .dpc_wr_en      (dpc_wr_en),
        .dpc_wr_data    (dpc_wr_data),
        .dbg_mode       (dbg_mode),
        .pipe_flush     (pipe_flush),
        .halted         (halted),
        .resumeack      (resumeack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dpc            (dpc),
        .dcsr_cause     (dcsr_cause)
    );

    task automatic chk(input string name, input string sig, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s got %0h expected %0h", name, sig, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        cpu_rst        = v.rst;
        breakpoint     = v.bp;
        pc_mem         = v.pcm;
        ebreak_ex      = v.eb;
        pc_ex          = v.pce;
        haltreq        = v.hr;
        resumereq      = v.rr;
        dcsr_step      = v.st;
        retire_valid   = v.rv;
        retire_next_pc = v.rnpc;
        pipe_empty     = v.pe;
        dpc_wr_en      = v.we;
        dpc_wr_data    = v.wd;
        @(posedge cpu_clk);
        #1;
        chk(name, "dbg_mode",       {31'd0, dbg_mode},       {31'd0, v.e_dbg});
        chk(name, "pipe_flush",     {31'd0, pipe_flush},     {31'd0, v.e_flush});
        chk(name, "halted",         {31'd0, halted},         {31'd0, v.e_halt});
        chk(name, "resumeack",      {31'd0, resumeack},      {31'd0, v.e_ack});
        chk(name, "redirect_valid", {31'd0, redirect_valid}, {31'd0, v.e_ack});
        chk(name, "redirect_pc",    redirect_pc,             v.e_dpc);
        chk(name, "dpc",            dpc,                     v.e_dpc);
        chk(name, "dcsr_cause",     {29'd0, dcsr_cause},     {29'd0, v.e_cause});
    endtask

    vec_t tbl [0:33];
    vec_t h;

    initial begin
        //          rst bp pcm       eb pce       hr rr st rv rnpc      pe we wd         dbg fl ha ak dpc       cause
        tbl[0]  = '{1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   3'd0};
        tbl[1]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h0,   3'd0};
        tbl[2]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0,   1, 1, 32'h999, 0, 0, 0, 0, 32'h0,   3'd0};
        tbl[3]  = '{0, 1, 32'h100, 0, 32'h104, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 0, 32'h100, 3'd2};
        tbl[4]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 0, 32'h100, 3'd2};
        tbl[5]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 0, 32'h100, 3'd2};
        tbl[6]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 0, 32'h100, 3'd2};
        tbl[7]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 1, 32'h400, 1, 0, 1, 0, 32'h400, 3'd2};
        tbl[8]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 0, 1, 32'h400, 3'd2};
        tbl[9]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h400, 3'd2};
        tbl[10] = '{0, 1, 32'h200, 1, 32'h204, 1, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 1, 0, 0, 32'h200, 3'd2};
        tbl[11] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 0, 32'h200, 3'd2};
        tbl[12] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 1, 32'h300, 1, 0, 1, 0, 32'h300, 3'd2};
        tbl[13] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 0, 32'h0,   1, 0, 0, 1, 32'h300, 3'd2};
        tbl[14] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h300, 3'd2};
        tbl[15] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h300, 3'd2};
        tbl[16] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 1, 32'h304, 1, 0, 32'h0,   1, 1, 0, 0, 32'h304, 3'd4};
        tbl[17] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 0, 32'h304, 3'd4};
        tbl[18] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 0, 32'h0,   1, 0, 0, 1, 32'h304, 3'd4};
        tbl[19] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h304, 3'd4};
        tbl[20] = '{0, 0, 32'h0,   1, 32'h30c, 0, 0, 1, 1, 32'h308, 0, 0, 32'h0,   1, 1, 0, 0, 32'h30c, 3'd1};
        tbl[21] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 0, 32'h30c, 3'd1};
        tbl[22] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 0, 32'h30c, 3'd1};
        tbl[23] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 0, 32'h0,   1, 0, 0, 1, 32'h30c, 3'd1};
        tbl[24] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h30c, 3'd1};
        tbl[25] = '{0, 0, 32'h0,   0, 32'h314, 1, 0, 1, 1, 32'h310, 1, 0, 32'h0,   1, 1, 0, 0, 32'h314, 3'd3};
        tbl[26] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 0, 32'h314, 3'd3};
        tbl[27] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 0, 1, 32'h314, 3'd3};
        tbl[28] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h314, 3'd3};
        tbl[29] = '{0, 0, 32'h0,   1, 32'h500, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 0, 32'h500, 3'd1};
        tbl[30] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 0, 32'h500, 3'd1};
        tbl[31] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 0, 1, 32'h500, 3'd1};
        tbl[32] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 0, 32'h500, 3'd1};
        tbl[33] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 32'h600, 1, 1, 32'h777, 0, 0, 0, 0, 32'h500, 3'd1};

        for (int i = 0; i <= 33; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // haltreq held across resume re-enters straight from RUN
        h = '{0, 0, 32'h0, 0, 32'h700, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0, 0, 32'h700, 3'd3};
        run_vec(h, "hold_enter");
        h = '{0, 0, 32'h0, 0, 32'h700, 1, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 1, 0, 32'h700, 3'd3};
        run_vec(h, "hold_halt");
        h = '{0, 0, 32'h0, 0, 32'h700, 1, 1, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 1, 32'h700, 3'd3};
        run_vec(h, "hold_resume");
        h = '{0, 0, 32'h0, 0, 32'h704, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h700, 3'd3};
        run_vec(h, "hold_run");
        h = '{0, 0, 32'h0, 0, 32'h704, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0, 0, 32'h704, 3'd3};
        run_vec(h, "hold_reenter");

        // reset while flushing
        h = '{1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 3'd0};
        run_vec(h, "rst_flush");
        h = '{0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 3'd0};
        run_vec(h, "rst_flush_idle");

        // reset while halted, with a resumereq that must not produce a redirect
        h = '{0, 1, 32'h800, 0, 32'h804, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 0, 0, 32'h800, 3'd2};
        run_vec(h, "rst_halt_enter");
        h = '{0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 1, 0, 32'h800, 3'd2};
        run_vec(h, "rst_halt_halted");
        h = '{1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 3'd0};
        run_vec(h, "rst_halt");
        h = '{0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 3'd0};
        run_vec(h, "rst_halt_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
